// File: rtl/switch_debounce_pkg.sv
// Shared constants for the switch/button input-conditioning bank.
// Downstream stages (e.g. the two-input XOR combiner) import SW_BANK_N_CH so
// the channel count stays consistent across the board.
package switch_debounce_pkg;

  // Number of switch/button channels on the board.
  localparam int unsigned SW_BANK_N_CH        = 2;
  // Default synchroniser depth per channel.
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;
  // Default stable-cycle requirement before a level change is accepted.
  localparam int unsigned DB_CYCLES_DEFAULT   = 1000000;

  // Counter width able to hold 0..db_cycles.
  function automatic int unsigned db_cnt_w(input int unsigned db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One debounce channel: synchroniser, stability counter, registered level,
// and optional registered rise/fall pulses.
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN (builds the pulse registers;
// otherwise rise_o/fall_o are constant 0).
// Ports:
//   clk     - sole clock
//   rst     - synchronous active-high reset
//   raw_i   - asynchronous switch level
//   out_o   - debounced level (registered)
//   rise_o  - one-cycle pulse when out_o goes 0->1
//   fall_o  - one-cycle pulse when out_o goes 1->0
module debounce_ch
  import switch_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned    CNT_W    = db_cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   s;
  logic                   flip;

  // Synchroniser shift, stability counter and level update.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    s      = sync_q[SYNC_STAGES-1];
    flip   = (s != out_q) && (cnt_q == CNT_TERM);
    out_d  = out_q;
    cnt_d  = '0;
    if (flip) begin
      out_d = s;
    end else if (s != out_q) begin
      // Cannot pass CNT_TERM: the terminal count always takes the flip branch.
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign out_o = out_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Pulses load on the same edge as out_q, so they coincide with the new level.
  always_comb begin
    rise_d = flip & s;
    fall_d = flip & ~s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce.sv
// Input-conditioning bank for raw switch/button pins: N_CH independent
// synchronise-and-debounce channels. The top level only fans ports out.
// Optional feature macro: SWITCH_DEBOUNCE_EDGE_EN (registered rise/fall
// pulses; when undefined rise/fall are constant 0, port list unchanged).
// Ports:
//   clk   - sole clock
//   rst   - synchronous active-high reset
//   raw   - [N_CH] asynchronous switch/button levels
//   out   - [N_CH] debounced registered levels
//   rise  - [N_CH] one-cycle pulse on out 0->1
//   fall  - [N_CH] one-cycle pulse on out 1->0
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned N_CH        = SW_BANK_N_CH,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  // Derived counter width; each channel computes the same value internally.
  localparam int unsigned CNT_W = db_cnt_w(DB_CYCLES);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw[i]),
      .out_o (out[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with N_CH=2, SYNC_STAGES=2, DB_CYCLES=4.
// Inputs change 1 time unit after a rising edge; the next edge is the first
// to sample them (edge k). Tick t after a change is edge k+t-1, so a held
// change appears on out at tick 6 (edge k+5).
module tb_switch_debounce;

  localparam int unsigned N_CH = 2;
  localparam int unsigned LAT  = 6;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] out;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  int n_total = 0;
  int n_bad   = 0;

  switch_debounce #(
    .N_CH       (N_CH),
    .SYNC_STAGES(2),
    .DB_CYCLES  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .raw (raw),
    .out (out),
    .rise(rise),
    .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N_CH-1:0] got,
                          input logic [N_CH-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b @%0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then sample 1 unit later and check all outputs.
  task automatic step(input string tag, input logic [N_CH-1:0] eo,
                      input logic [N_CH-1:0] er, input logic [N_CH-1:0] ef);
    @(posedge clk);
    #1;
    check_eq({tag, ".out"},  out,  eo);
    check_eq({tag, ".rise"}, rise, EDGE_EN ? er : '0);
    check_eq({tag, ".fall"}, fall, EDGE_EN ? ef : '0);
  endtask

  // Clean held change from level 'from' to 'to', observed for n ticks.
  task automatic settle(input string tag, input logic [N_CH-1:0] from,
                        input logic [N_CH-1:0] to, input int n);
    raw = to;
    for (int t = 1; t <= n; t++) begin
      step($sformatf("%s.t%0d", tag, t),
           (t >= LAT) ? to : from,
           (t == LAT) ? (to & ~from) : '0,
           (t == LAT) ? (from & ~to) : '0);
    end
  endtask

  initial begin
    rst = 1'b1;
    raw = 2'b11;

    // Reset held 3 cycles with raw high: everything stays 0.
    for (int t = 1; t <= 3; t++) step($sformatf("rst.t%0d", t), 2'b00, 2'b00, 2'b00);

    // Release: next edge is the release edge; out rises at release+5.
    rst = 1'b0;
    settle("rel", 2'b00, 2'b11, 7);
    settle("both_fall", 2'b11, 2'b00, 7);

    // Clean rise on channel 0 only; out[1] stays 0.
    settle("rise0", 2'b00, 2'b01, 8);
    settle("fall0", 2'b01, 2'b00, 7);

    // 3-cycle pulse on channel 1 is rejected.
    raw = 2'b10;
    for (int t = 1; t <= 10; t++) begin
      if (t == 4) raw = 2'b00;
      step($sformatf("glitch3.t%0d", t), 2'b00, 2'b00, 2'b00);
    end

    // 4-cycle pulse on channel 1: out high ticks 6..9, rise at 6, fall at 10.
    raw = 2'b10;
    for (int t = 1; t <= 12; t++) begin
      if (t == 5) raw = 2'b00;
      step($sformatf("pulse4.t%0d", t),
           (t >= 6 && t <= 9) ? 2'b10 : 2'b00,
           (t == 6)  ? 2'b10 : 2'b00,
           (t == 10) ? 2'b10 : 2'b00);
    end

    // Bounce on channel 0: 2-cycle segments never reach the terminal count.
    for (int seg = 0; seg < 10; seg++) begin
      raw = (seg % 2 == 0) ? 2'b01 : 2'b00;
      for (int t = 1; t <= 2; t++)
        step($sformatf("bounce.s%0d.t%0d", seg, t), 2'b00, 2'b00, 2'b00);
    end
    settle("bounce_settle", 2'b00, 2'b01, 9);
    settle("bounce_clr", 2'b01, 2'b00, 7);

    // Reset while channel 0 has counted to 2 (after tick 4).
    raw = 2'b01;
    for (int t = 1; t <= 4; t++) step($sformatf("mid.t%0d", t), 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    for (int t = 1; t <= 3; t++) step($sformatf("mid_rst.t%0d", t), 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    settle("mid_rel", 2'b00, 2'b01, 8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
